music_player: RTL

Sequencer that reads a song ROM, which maps an 8-bit address to an 8-bit note with 1-cycle registered latency, and drives a square-wave tone on a speaker pin. It steps the ROM address at a fixed tempo and converts each note number to a half-period divider. Note 0 means rest. A long note is encoded as repeated ROM entries and plays legato without a phase restart. It sits between a song ROM and the speaker pin, and is controlled by start/stop/loop from top-level logic.

---
 rtl/music_pkg.sv | 24 ++
 rtl/music_player_note_to_divider.sv | 43 ++++
 rtl/music_player.sv | 112 +++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared constants for the song sequencer: the note table, note limits and the FSM states.
package music_pkg;

  localparam int                 TABLE_CLK_HZ = 48000000;
  localparam int                 TABLE_W      = 20;
  localparam logic [7:0]         NOTE_REST    = 8'd0;
  localparam logic [7:0]         NOTE_MAX     = 8'd96;

  // Half-period, in clocks, of octave-1 semitones C1..B1 (C1 = 32.7032 Hz).
  localparam logic [TABLE_W-1:0] BASE_HALF [12] = '{
    20'd733873, 20'd692684, 20'd653807, 20'd617111,
    20'd582476, 20'd549784, 20'd518927, 20'd489802,
    20'd462311, 20'd436364, 20'd411872, 20'd388756
  };

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PLAY,
    DONE
  } state_e;

endpackage

// File: rtl/music_player_note_to_divider.sv
// Maps a note number to the half-period of its square wave, or flags it as a rest.
module note_to_divider
  import music_pkg::*;
#(
  parameter int CLK_HZ = TABLE_CLK_HZ,
  parameter int DIV_W  = 20
) (
  input  logic [7:0]       i_note,
  output logic [DIV_W-1:0] o_half,
  output logic             o_is_rest
);

  logic [6:0]         w_idx;
  logic [6:0]         w_base;
  logic [2:0]         w_oct;
  logic [3:0]         w_semi;
  logic [TABLE_W-1:0] w_half_ref;

  assign o_is_rest = (i_note == NOTE_REST) || (i_note > NOTE_MAX);

  // Octave/semitone split by threshold compare instead of a divider.
  always_comb begin
    w_idx  = o_is_rest ? 7'd0 : 7'(i_note - 8'd1);
    w_oct  = '0;
    w_base = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_idx >= 7'(12 * k)) begin
        w_oct  = 3'(k);
        w_base = 7'(12 * k);
      end
    end
    w_semi     = 4'(w_idx - w_base);
    w_half_ref = o_is_rest ? '0 : (BASE_HALF[w_semi] >> w_oct);
  end

  // The table is exact at its native clock; other clocks rescale by a constant ratio.
  if (CLK_HZ == TABLE_CLK_HZ) begin : g_native
    assign o_half = DIV_W'(w_half_ref);
  end else begin : g_scaled
    assign o_half = DIV_W'((64'(w_half_ref) * 64'(CLK_HZ)) / 64'(TABLE_CLK_HZ));
  end

endmodule

// File: rtl/music_player.sv
// Song sequencer: steps a registered song ROM at a fixed tempo and plays each
// note as a square wave, keeping phase across repeated notes.
module music_player
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 48000000,
  parameter int STEP_CYCLES = 6000000,
  parameter int SONG_LEN    = 241,
  parameter int DIV_W       = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_loop,
  output logic [7:0] o_rom_addr,
  input  logic [7:0] i_rom_note,
  output logic       o_speaker,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_cur_note
);

  localparam int            SW        = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(SONG_LEN - 1);

  state_e           r_state, w_next;
  logic [7:0]       r_addr, r_note;
  logic [SW-1:0]    r_step;
  logic [DIV_W-1:0] r_tone, r_half, w_half;
  logic             r_spk;
  logic             w_is_rest, w_busy, w_step_end, w_last, w_wrap;

  note_to_divider #(
    .CLK_HZ(CLK_HZ),
    .DIV_W (DIV_W)
  ) u_n2d (
    .i_note   (i_rom_note),
    .o_half   (w_half),
    .o_is_rest(w_is_rest)
  );

  assign w_busy     = (r_state == FETCH) || (r_state == LATCH) || (r_state == PLAY);
  assign w_step_end = (r_step == STEP_LAST);
  assign w_last     = (r_addr == ADDR_LAST);
  assign w_wrap     = (r_tone == r_half - DIV_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_start && !i_stop) w_next = FETCH;
      FETCH, LATCH, PLAY: begin
        if (i_stop)                  w_next = IDLE;
        else if (w_step_end)         w_next = (w_last && !i_loop) ? DONE : FETCH;
        else if (r_state == FETCH)   w_next = LATCH;
        else if (r_state == LATCH)   w_next = PLAY;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_step  <= '0;
      r_tone  <= '0;
      r_half  <= '0;
      r_note  <= '0;
      r_spk   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE || w_next == DONE) begin
        r_addr <= '0;
        r_step <= '0;
        r_tone <= '0;
        r_half <= '0;
        r_note <= '0;
        r_spk  <= 1'b0;
      end else if (!w_busy) begin
        r_addr <= '0;
        r_step <= '0;
      end else begin
        r_step <= w_step_end ? '0 : r_step + SW'(1);
        if (w_step_end) r_addr <= w_last ? '0 : r_addr + 8'd1;
        // A repeated note falls through to the free-running tone path (legato).
        if (r_state == LATCH && (w_is_rest || i_rom_note != r_note)) begin
          r_note <= w_is_rest ? NOTE_REST : i_rom_note;
          r_half <= w_half;
          r_tone <= '0;
          r_spk  <= 1'b0;
        end else if (r_note != NOTE_REST) begin
          if (w_wrap) begin
            r_tone <= '0;
            r_spk  <= ~r_spk;
          end else begin
            r_tone <= r_tone + DIV_W'(1);
          end
        end
      end
    end
  end

  assign o_rom_addr = r_addr;
  assign o_speaker  = r_spk;
  assign o_busy     = w_busy;
  assign o_done     = (r_state == DONE);
  assign o_cur_note = r_note;

endmodule
